// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the priority interrupt controller: default source
// count and the presentation FSM state type.
package intr_ctrl_pkg;

  localparam int NUM_PER_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRESENT  = 2'd1,
    S_WAIT_CLR = 2'd2
  } state_t;

endpackage

// File: rtl/intr_ctrl_if.sv
// APB-style priority-register access bus of the interrupt controller.
interface intr_ctrl_if
  import intr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = $clog2(NUM_PER_DEFAULT)
);
  logic [ADDR_WIDTH-1:0] paddr_i;
  logic [ADDR_WIDTH-1:0] pwdata_i;
  logic                  pwrite_i;
  logic                  psel_i;
  logic                  penable_i;
  logic                  pready_o;
  logic [ADDR_WIDTH-1:0] prdata_o;

  modport master (
    output paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
    input  pready_o, prdata_o
  );

  modport slave (
    input  paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
    output pready_o, prdata_o
  );
endinterface

// File: rtl/intr_ctrl_arbiter.sv
// Combinational priority arbiter: highest priority value wins, ties go to
// the lowest source index.
module intr_prio_arbiter
  import intr_ctrl_pkg::*;
#(
  parameter int NUM_PER    = NUM_PER_DEFAULT,
  parameter int ADDR_WIDTH = $clog2(NUM_PER)
) (
  input  logic [NUM_PER-1:0]            active_i,
  input  logic [NUM_PER*ADDR_WIDTH-1:0] prio_flat_i,
  output logic                          found_o,
  output logic [ADDR_WIDTH-1:0]         idx_o
);

  logic [ADDR_WIDTH-1:0] w_best;
  logic [ADDR_WIDTH-1:0] w_cur;
  logic                  w_take;

  // Ascending scan with strict compare keeps the lowest index on ties.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    w_best  = '0;
    w_cur   = '0;
    w_take  = 1'b0;
    for (int i = 0; i < NUM_PER; i++) begin
      w_cur   = prio_flat_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_take  = active_i[i] & (~found_o | (w_cur > w_best));
      idx_o   = w_take ? ADDR_WIDTH'(i) : idx_o;
      w_best  = w_take ? w_cur : w_best;
      found_o = found_o | w_take;
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Priority interrupt controller with APB-programmable per-source priorities.
// Define INTR_CTRL_PRIO_READ_EN to enable priority register readback.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int NUM_PER    = NUM_PER_DEFAULT,
  parameter int ADDR_WIDTH = $clog2(NUM_PER)
) (
  input  logic                  pclk_i,
  input  logic                  prst_i,
  intr_ctrl_if.slave            apb,
  output logic                  intr_valid_o,
  output logic [ADDR_WIDTH-1:0] intr_to_service_o,
  input  logic                  intr_serviced_i,
  input  logic [NUM_PER-1:0]    int_active_i
);

  logic [ADDR_WIDTH-1:0]         r_prio [NUM_PER];
  logic [NUM_PER*ADDR_WIDTH-1:0] w_prio_flat;
  logic                          w_xfer;
  logic                          w_found;
  logic [ADDR_WIDTH-1:0]         w_winner;
  state_t                        r_state;
  state_t                        w_state_nxt;
  logic                          r_valid;
  logic                          w_valid_nxt;
  logic [ADDR_WIDTH-1:0]         r_idx;
  logic [ADDR_WIDTH-1:0]         w_idx_nxt;

  assign w_xfer       = apb.psel_i & apb.penable_i;
  assign apb.pready_o = w_xfer & ~prst_i;

  // Flatten the priority array for the arbiter.
  always_comb begin
    w_prio_flat = '0;
    for (int i = 0; i < NUM_PER; i++) begin
      w_prio_flat[i*ADDR_WIDTH +: ADDR_WIDTH] = r_prio[i];
    end
  end

  // Priority register file; reset wins over a coincident write.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      for (int i = 0; i < NUM_PER; i++) begin
        r_prio[i] <= '0;
      end
    end else if (w_xfer && apb.pwrite_i) begin
      r_prio[apb.paddr_i] <= apb.pwdata_i;
    end
  end

`ifdef INTR_CTRL_PRIO_READ_EN
  logic [ADDR_WIDTH-1:0] r_prdata;

  // Registered readback, held between read transfers.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      r_prdata <= '0;
    end else if (w_xfer && !apb.pwrite_i) begin
      r_prdata <= r_prio[apb.paddr_i];
    end
  end

  assign apb.prdata_o = r_prdata;
`else
  assign apb.prdata_o = '0;
`endif

  intr_prio_arbiter #(
    .NUM_PER    (NUM_PER),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_arb (
    .active_i    (int_active_i),
    .prio_flat_i (w_prio_flat),
    .found_o     (w_found),
    .idx_o       (w_winner)
  );

  // Next state. S_WAIT_CLR is the single valid-low cycle after an ack; its
  // exit edge arbitrates like S_IDLE so a still-pending source is presented
  // right after it, giving exactly one idle cycle between services.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE, S_WAIT_CLR: begin
        if (w_found) begin
          w_state_nxt = S_PRESENT;
          w_valid_nxt = 1'b1;
          w_idx_nxt   = w_winner;
        end else begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
        end
      end
      S_PRESENT: begin
        if (intr_serviced_i) begin
          w_state_nxt = S_WAIT_CLR;
          w_valid_nxt = 1'b0;
        end else begin
          w_state_nxt = S_PRESENT;
          w_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // FSM state and registered presentation outputs.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  assign intr_valid_o      = r_valid;
  assign intr_to_service_o = r_idx;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a behavioural reference model.
module tb_intr_ctrl;
  localparam int NP = 16;
  localparam int AW = 4;
`ifdef INTR_CTRL_PRIO_READ_EN
  localparam bit RD_EN = 1'b1;
`else
  localparam bit RD_EN = 1'b0;
`endif

  logic          pclk_i = 1'b0;
  logic          prst_i;
  logic          intr_valid_o;
  logic [AW-1:0] intr_to_service_o;
  logic          intr_serviced_i;
  logic [NP-1:0] int_active_i;

  intr_ctrl_if #(.ADDR_WIDTH(AW)) apb ();

  intr_ctrl #(.NUM_PER(NP), .ADDR_WIDTH(AW)) dut (
    .pclk_i            (pclk_i),
    .prst_i            (prst_i),
    .apb               (apb),
    .intr_valid_o      (intr_valid_o),
    .intr_to_service_o (intr_to_service_o),
    .intr_serviced_i   (intr_serviced_i),
    .int_active_i      (int_active_i)
  );

  always #5 pclk_i = ~pclk_i;

  int m_prio [NP];
  bit m_valid;
  int m_idx;
  int m_prdata;
  int n_cmp = 0;
  int n_fail = 0;

  // Highest priority value first, then lowest index.
  function automatic int ref_winner(logic [NP-1:0] act);
    for (int p = (1 << AW) - 1; p >= 0; p--)
      for (int i = 0; i < NP; i++)
        if (act[i] && m_prio[i] == p) return i;
    return -1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int  w;
    bit  xfer;
    #1;
    xfer = apb.psel_i & apb.penable_i;
    check("pready", {31'd0, apb.pready_o}, {31'd0, xfer & ~prst_i});
    if (prst_i) begin
      foreach (m_prio[i]) m_prio[i] = 0;
      m_valid = 0; m_idx = 0; m_prdata = 0;
    end else begin
      w = ref_winner(int_active_i);
      if (xfer && !apb.pwrite_i) m_prdata = RD_EN ? m_prio[apb.paddr_i] : 0;
      if (m_valid) begin
        if (intr_serviced_i) m_valid = 0;
      end else if (w >= 0) begin
        m_valid = 1; m_idx = w;
      end
      if (xfer && apb.pwrite_i) m_prio[apb.paddr_i] = int'(apb.pwdata_i);
    end
    @(posedge pclk_i);
    #1;
    check("valid", {31'd0, intr_valid_o}, {31'd0, m_valid});
    check("idx", {28'd0, intr_to_service_o}, m_idx);
    check("prdata", {28'd0, apb.prdata_o}, m_prdata);
  endtask

  task automatic apb_write(int a, int d);
    apb.paddr_i = AW'(a); apb.pwdata_i = AW'(d);
    apb.psel_i = 1'b1; apb.penable_i = 1'b1; apb.pwrite_i = 1'b1;
    tick();
    apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
  endtask

  task automatic apb_read(int a);
    apb.paddr_i = AW'(a);
    apb.psel_i = 1'b1; apb.penable_i = 1'b1; apb.pwrite_i = 1'b0;
    tick();
    apb.psel_i = 1'b0; apb.penable_i = 1'b0;
  endtask

  task automatic ack_all();
    intr_serviced_i = 1'b1; int_active_i = '0;
    tick();
    intr_serviced_i = 1'b0;
    tick();
  endtask

  initial begin
    int exp_seq [4] = '{15, 10, 5, 0};
    prst_i = 1'b1; intr_serviced_i = 1'b0; int_active_i = '0;
    apb.paddr_i = '0; apb.pwdata_i = '0; apb.pwrite_i = 1'b0;
    apb.psel_i = 1'b0; apb.penable_i = 1'b0;
    foreach (m_prio[i]) m_prio[i] = 0;
    m_valid = 0; m_idx = 0; m_prdata = 0;
    tick(); tick();
    check("rst_valid", {31'd0, intr_valid_o}, 32'd0);
    prst_i = 1'b0;

    // Write without psel must not land (prio[3]=15 would win below).
    apb.psel_i = 1'b0; apb.penable_i = 1'b1; apb.pwrite_i = 1'b1;
    apb.paddr_i = 4'd3; apb.pwdata_i = 4'd15;
    tick();
    apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
    int_active_i = 16'h0009;
    tick();
    check("nosel_idx", {28'd0, intr_to_service_o}, 32'd0);
    ack_all();

    // prio[i] = 16-i, truncated to 4 bits.
    for (int i = 0; i < NP; i++) apb_write(i, 16 - i);
    int_active_i = 16'h0011;
    check("lat_pre", {31'd0, intr_valid_o}, 32'd0);
    tick();
    check("r034_valid", {31'd0, intr_valid_o}, 32'd1);
    check("r034_idx", {28'd0, intr_to_service_o}, 32'd4);
    ack_all();

    // All-equal priorities: lowest index wins.
    for (int i = 0; i < NP; i++) apb_write(i, 0);
    int_active_i = 16'h0006;
    tick();
    check("tie_idx", {28'd0, intr_to_service_o}, 32'd1);
    ack_all();

    // prio[i] = i, serviced in descending order, one idle cycle between.
    for (int i = 0; i < NP; i++) apb_write(i, i);
    int_active_i = 16'h8421;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("seq_valid", {31'd0, intr_valid_o}, 32'd1);
      check("seq_idx", {28'd0, intr_to_service_o}, exp_seq[k]);
      intr_serviced_i = 1'b1;
      int_active_i[exp_seq[k]] = 1'b0;
      tick();
      intr_serviced_i = 1'b0;
      check("seq_gap", {31'd0, intr_valid_o}, 32'd0);
      tick();
    end
    check("seq_end", {31'd0, intr_valid_o}, 32'd0);

    // Higher-priority source raised while presenting is deferred.
    int_active_i = 16'h0004;
    tick();
    check("hold_idx0", {28'd0, intr_to_service_o}, 32'd2);
    int_active_i = 16'h0804;
    tick(); tick();
    check("hold_idx1", {28'd0, intr_to_service_o}, 32'd2);
    intr_serviced_i = 1'b1; int_active_i = 16'h0800;
    tick();
    intr_serviced_i = 1'b0;
    check("hold_gap", {31'd0, intr_valid_o}, 32'd0);
    tick();
    check("hold_new", {28'd0, intr_to_service_o}, 32'd11);

    // Reset mid-service with a coincident write: reset wins.
    prst_i = 1'b1;
    apb.paddr_i = 4'd5; apb.pwdata_i = 4'd9;
    apb.psel_i = 1'b1; apb.penable_i = 1'b1; apb.pwrite_i = 1'b1;
    tick();
    check("rst_mid_valid", {31'd0, intr_valid_o}, 32'd0);
    check("rst_mid_idx", {28'd0, intr_to_service_o}, 32'd0);
    prst_i = 1'b0; int_active_i = '0;
    apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
    for (int i = 0; i < NP; i++) begin
      apb_read(i);
      check("rst_rd", {28'd0, apb.prdata_o}, 32'd0);
    end
    int_active_i = 16'h0021;
    tick();
    check("rst_prio_idx", {28'd0, intr_to_service_o}, 32'd0);
    ack_all();

    // Randomized traffic checked against the model every cycle.
    for (int c = 0; c < 600; c++) begin
      prst_i          = ($urandom_range(0, 99) == 0);
      apb.psel_i      = 1'($urandom_range(0, 1));
      apb.penable_i   = 1'($urandom_range(0, 1));
      apb.pwrite_i    = 1'($urandom_range(0, 1));
      apb.paddr_i     = AW'($urandom_range(0, NP - 1));
      apb.pwdata_i    = AW'($urandom_range(0, (1 << AW) - 1));
      if ($urandom_range(0, 3) == 0) int_active_i = NP'($urandom() & $urandom());
      intr_serviced_i = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
